// File: rtl/mem_arbiter_pkg.sv
// Shared state and grant encodings for the I/D memory-port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    MARB_IDLE    = 3'd0,
    MARB_I_BURST = 3'd1,
    MARB_D_BURST = 3'd2,
    MARB_I_DONE  = 3'd3,
    MARB_D_DONE  = 3'd4
  } marb_state_t;

  localparam logic MARB_GNT_I = 1'b0;
  localparam logic MARB_GNT_D = 1'b1;

endpackage

// File: rtl/mem_burst_counter.sv
// Beat counter for one cache-line burst: clear on grant, step per beat,
// flag the final beat. Wraps to zero naturally after the last beat.
module mem_burst_counter #(
  parameter  int LINE_WORDS = 4,
  localparam int CW         = $clog2(LINE_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache refills and
// D-cache refills/write-backs; one LINE_WORDS burst per grant, then a done pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int LINE_WORDS = 4,
  parameter  int ADDR_W     = 32,
  parameter  int DATA_W     = 32,
  localparam int CW         = $clog2(LINE_WORDS)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_imiss_req,
  input  logic [ADDR_W-1:0] i_imiss_addr,
  output logic [DATA_W-1:0] o_imiss_rdata,
  output logic              o_imiss_rvalid,
  output logic              o_imiss_done,
  input  logic              i_dmiss_req,
  input  logic              i_dmiss_we,
  input  logic [ADDR_W-1:0] i_dmiss_addr,
  input  logic [DATA_W-1:0] i_dmiss_wdata,
  output logic              o_dmiss_wnext,
  output logic [DATA_W-1:0] o_dmiss_rdata,
  output logic              o_dmiss_rvalid,
  output logic              o_dmiss_done,
  output logic [CW-1:0]     o_word_idx,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

  marb_state_t       state;
  logic              last_grant;
  logic [ADDR_W-1:0] base;
  logic              we_q;
  logic [CW-1:0]     cnt;
  logic              last_beat;
  logic              gnt_i, gnt_d;
  logic              in_i, in_d, beat;

  // D wins a tie only when I held the previous grant.
  assign gnt_d = (state == MARB_IDLE) && i_dmiss_req &&
                 (!i_imiss_req || (last_grant == MARB_GNT_I));
  assign gnt_i = (state == MARB_IDLE) && i_imiss_req && !gnt_d;

  assign in_i = (state == MARB_I_BURST);
  assign in_d = (state == MARB_D_BURST);
  assign beat = (in_i || in_d) && i_mem_ready;

  mem_burst_counter #(.LINE_WORDS(LINE_WORDS)) u_cnt (
    .clk   (Clk),
    .rst_n (Rst),
    .clr   (gnt_i || gnt_d),
    .inc   (beat),
    .cnt   (cnt),
    .last  (last_beat)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= MARB_IDLE;
      last_grant <= MARB_GNT_I;
      base       <= '0;
      we_q       <= 1'b0;
    end else begin
      case (state)
        MARB_IDLE: begin
          if (gnt_d) begin
            state      <= MARB_D_BURST;
            last_grant <= MARB_GNT_D;
            base       <= i_dmiss_addr & ~LINE_MASK;
            we_q       <= i_dmiss_we;
          end else if (gnt_i) begin
            state      <= MARB_I_BURST;
            last_grant <= MARB_GNT_I;
            base       <= i_imiss_addr & ~LINE_MASK;
            we_q       <= 1'b0;
          end
        end
        MARB_I_BURST: if (beat && last_beat) state <= MARB_I_DONE;
        MARB_D_BURST: if (beat && last_beat) state <= MARB_D_DONE;
        default:      state <= MARB_IDLE;
      endcase
    end
  end

  // Data paths are gated by state so that every output is zero outside its burst.
  assign o_mem_req      = in_i || in_d;
  assign o_mem_we       = in_d && we_q;
  assign o_mem_addr     = o_mem_req ? (base | ADDR_W'({cnt, 2'b00})) : '0;
  assign o_mem_wdata    = (in_d && we_q) ? i_dmiss_wdata : '0;
  assign o_imiss_rvalid = in_i && i_mem_ready;
  assign o_imiss_rdata  = in_i ? i_mem_rdata : '0;
  assign o_dmiss_rvalid = in_d && !we_q && i_mem_ready;
  assign o_dmiss_rdata  = (in_d && !we_q) ? i_mem_rdata : '0;
  assign o_dmiss_wnext  = in_d && we_q && i_mem_ready;
  assign o_imiss_done   = (state == MARB_I_DONE);
  assign o_dmiss_done   = (state == MARB_D_DONE);
  assign o_word_idx     = cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: single-burst vector table, hand-written arbitration,
// drop and reset sequences, then random traffic against a line-level model.
module tb_mem_arbiter;

  localparam int LW = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        i_imiss_req = 1'b0;
  logic [31:0] i_imiss_addr = '0;
  logic [31:0] o_imiss_rdata;
  logic        o_imiss_rvalid, o_imiss_done;
  logic        i_dmiss_req = 1'b0;
  logic        i_dmiss_we = 1'b0;
  logic [31:0] i_dmiss_addr = '0;
  logic [31:0] i_dmiss_wdata = '0;
  logic        o_dmiss_wnext;
  logic [31:0] o_dmiss_rdata;
  logic        o_dmiss_rvalid, o_dmiss_done;
  logic [1:0]  o_word_idx;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ready = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(32), .DATA_W(32)) dut (
    .Clk(Clk), .Rst(Rst),
    .i_imiss_req(i_imiss_req), .i_imiss_addr(i_imiss_addr),
    .o_imiss_rdata(o_imiss_rdata), .o_imiss_rvalid(o_imiss_rvalid), .o_imiss_done(o_imiss_done),
    .i_dmiss_req(i_dmiss_req), .i_dmiss_we(i_dmiss_we), .i_dmiss_addr(i_dmiss_addr),
    .i_dmiss_wdata(i_dmiss_wdata), .o_dmiss_wnext(o_dmiss_wnext),
    .o_dmiss_rdata(o_dmiss_rdata), .o_dmiss_rvalid(o_dmiss_rvalid), .o_dmiss_done(o_dmiss_done),
    .o_word_idx(o_word_idx), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [7:0]  rdy;        // ready per burst cycle, LSB first; 1 afterwards
    logic [31:0] exp_base;
    int          exp_cycles; // cycles with o_mem_req high
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {25'b0, o_mem_req, o_mem_we, o_imiss_rvalid, o_dmiss_rvalid,
                        o_dmiss_wnext, o_imiss_done, o_dmiss_done}, 32'h0);
    chk({tag, "_addr"}, o_mem_addr, 32'h0);
    chk({tag, "_idx"}, o_word_idx, 32'h0);
    chk({tag, "_data"}, o_imiss_rdata | o_dmiss_rdata | o_mem_wdata, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b0;
    i_imiss_req = 1'b0;
    i_dmiss_req = 1'b0;
    i_mem_rdata = 32'hDEAD_BEEF;
    i_dmiss_wdata = 32'hCAFE_F00D;
    #1 check_zero("reset");
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic run_burst(input vec_t v, input string tag);
    int beats, cyc;
    bit rd_i, rd_d, wr_d;
    rd_i = !v.is_d;
    rd_d = v.is_d && !v.we;
    wr_d = v.is_d && v.we;
    @(negedge Clk);
    i_mem_ready = 1'b0;
    if (v.is_d) begin
      i_dmiss_req = 1'b1; i_dmiss_we = v.we; i_dmiss_addr = v.addr;
    end else begin
      i_imiss_req = 1'b1; i_imiss_addr = v.addr;
    end
    #1 chk({tag, "_req_before_grant"}, o_mem_req, 0);
    beats = 0;
    cyc = 0;
    while (beats < LW && cyc < 40) begin
      @(negedge Clk);
      i_mem_ready   = (cyc < 8) ? v.rdy[cyc] : 1'b1;
      i_mem_rdata   = 32'hA0 + beats;
      i_dmiss_wdata = 32'hB0 + beats;
      #1;
      chk({tag, "_req"}, o_mem_req, 1);
      chk({tag, "_addr"}, o_mem_addr, v.exp_base + 4 * beats);
      chk({tag, "_we"}, o_mem_we, wr_d);
      chk({tag, "_idx"}, o_word_idx, beats);
      chk({tag, "_irvalid"}, o_imiss_rvalid, rd_i && i_mem_ready);
      chk({tag, "_drvalid"}, o_dmiss_rvalid, rd_d && i_mem_ready);
      chk({tag, "_wnext"}, o_dmiss_wnext, wr_d && i_mem_ready);
      chk({tag, "_done_early"}, {o_imiss_done, o_dmiss_done}, 0);
      if (rd_i && i_mem_ready) chk({tag, "_irdata"}, o_imiss_rdata, 32'hA0 + beats);
      if (rd_d && i_mem_ready) chk({tag, "_drdata"}, o_dmiss_rdata, 32'hA0 + beats);
      if (wr_d) chk({tag, "_wdata"}, o_mem_wdata, 32'hB0 + beats);
      if (i_mem_ready) beats++;
      cyc++;
    end
    chk({tag, "_burst_cycles"}, cyc, v.exp_cycles);
    @(negedge Clk);
    #1;
    chk({tag, "_done"}, {o_imiss_done, o_dmiss_done}, v.is_d ? 2'b01 : 2'b10);
    chk({tag, "_done_req"}, o_mem_req, 0);
    chk({tag, "_done_idx"}, o_word_idx, 0);
    i_imiss_req = 1'b0;
    i_dmiss_req = 1'b0;
    @(negedge Clk);
    #1;
    chk({tag, "_idle"}, {o_mem_req, o_imiss_done, o_dmiss_done}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int got, cyc, beats;
    bit order[4];
    bit exp_order[4];
    bit found, done_seen;
    // line-level reference model for random traffic
    int   ph;      // 0 idle, 1 transferring, 2 done pulse
    bit   own;     // 0 = I, 1 = D
    bit   rr_last; // 0 = I served last
    int   k;
    logic [31:0] mbase;
    bit   mwe;
    bit   e_busy, e_irv, e_drv, e_wn, e_we;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_104C, 8'hFF, 32'h0000_1040, 4};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 8'h39, 32'h0000_2000, 6};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_3008, 8'hFF, 32'h0000_3000, 4};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 8'h55, 32'hFFFF_FFF0, 7};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_001C, 8'h0E, 32'h0000_0010, 9};

    do_reset();
    for (int i = 0; i < 5; i++) run_burst(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests: both requesters keep re-requesting after done.
    do_reset();
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
    i_imiss_addr = 32'h5000; i_dmiss_addr = 32'h6000; i_dmiss_we = 1'b0;
    i_mem_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 60) begin
      @(negedge Clk);
      i_imiss_req = 1'b1;
      i_dmiss_req = 1'b1;
      #1;
      if (o_imiss_done && got < 4) begin order[got] = 1'b0; got++; i_imiss_req = 1'b0; end
      if (o_dmiss_done && got < 4) begin order[got] = 1'b1; got++; i_dmiss_req = 1'b0; end
      cyc++;
    end
    chk("rr_grant_count", got, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
    @(negedge Clk);
    i_imiss_req = 1'b0; i_dmiss_req = 1'b0;
    repeat (3) @(negedge Clk);

    // I requester drops its request after two beats.
    i_imiss_req = 1'b1; i_imiss_addr = 32'h7000; i_mem_ready = 1'b1;
    beats = 0; cyc = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 20) begin
      @(negedge Clk);
      #1;
      if (o_imiss_rvalid) beats++;
      if (beats == 2) i_imiss_req = 1'b0;
      if (o_imiss_done) done_seen = 1'b1;
      cyc++;
    end
    chk("drop_beats", beats, 4);
    chk("drop_done", done_seen, 1);
    repeat (2) begin
      @(negedge Clk);
      #1 chk("drop_idle", {o_mem_req, o_imiss_done, o_word_idx}, 0);
    end

    // Reset in the middle of a D write-back.
    i_dmiss_req = 1'b1; i_dmiss_we = 1'b1; i_dmiss_addr = 32'h8000; i_mem_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge Clk);
      #1;
      if (o_mem_req && o_word_idx == 2'd2) found = 1'b1;
    end
    chk("rst_mid_reached", found, 1);
    Rst = 1'b0;
    i_dmiss_req = 1'b0;
    #1 check_zero("rst_mid");
    @(negedge Clk);
    Rst = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      #1 chk("rst_no_done", {o_imiss_done, o_dmiss_done, o_mem_req}, 0);
    end
    run_burst('{1'b0, 1'b0, 32'h0000_9000, 8'hFF, 32'h0000_9000, 4}, "post_rst");

    // Random traffic against the line-level model.
    do_reset();
    ph = 0; own = 1'b0; rr_last = 1'b0; k = 0; mbase = '0; mwe = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge Clk);
      if (ph == 2) begin
        if (own) i_dmiss_req = 1'b0; else i_imiss_req = 1'b0;
      end else begin
        if (!i_imiss_req && $urandom_range(0, 3) == 0) begin
          i_imiss_req = 1'b1; i_imiss_addr = $urandom;
        end
        if (!i_dmiss_req && $urandom_range(0, 3) == 0) begin
          i_dmiss_req = 1'b1; i_dmiss_addr = $urandom; i_dmiss_we = 1'($urandom_range(0, 1));
        end
      end
      i_mem_ready   = ($urandom_range(0, 3) != 0);
      i_mem_rdata   = $urandom;
      i_dmiss_wdata = $urandom;
      #1;
      e_busy = (ph == 1);
      e_we   = e_busy && own && mwe;
      e_irv  = e_busy && !own && i_mem_ready;
      e_drv  = e_busy && own && !mwe && i_mem_ready;
      e_wn   = e_busy && own && mwe && i_mem_ready;
      chk("rnd_ctl", {25'b0, o_mem_req, o_mem_we, o_imiss_rvalid, o_dmiss_rvalid, o_dmiss_wnext,
                      o_imiss_done, o_dmiss_done},
          {25'b0, e_busy, e_we, e_irv, e_drv, e_wn, (ph == 2) && !own, (ph == 2) && own});
      chk("rnd_idx", o_word_idx, k);
      if (e_busy) chk("rnd_addr", o_mem_addr, mbase + 4 * k);
      if (e_irv) chk("rnd_irdata", o_imiss_rdata, i_mem_rdata);
      if (e_drv) chk("rnd_drdata", o_dmiss_rdata, i_mem_rdata);
      if (e_we) chk("rnd_wdata", o_mem_wdata, i_dmiss_wdata);
      if (ph == 0) begin
        if (i_dmiss_req && (!i_imiss_req || !rr_last)) begin
          ph = 1; own = 1'b1; rr_last = 1'b1; k = 0;
          mbase = i_dmiss_addr & ~32'(LW * 4 - 1); mwe = i_dmiss_we;
        end else if (i_imiss_req) begin
          ph = 1; own = 1'b0; rr_last = 1'b0; k = 0;
          mbase = i_imiss_addr & ~32'(LW * 4 - 1); mwe = 1'b0;
        end
      end else if (ph == 1) begin
        if (i_mem_ready) begin
          k = (k + 1) % LW;
          if (k == 0) ph = 2;
        end
      end else begin
        ph = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one external memory port between the instruction-cache refill path (IF stage, read-only) and the data-cache miss path (MA stage, line refill or line write-back).
- Issues one burst of LINE_WORDS word transfers per grant.
- Uses round-robin arbitration when both paths request together.
- Sits below the IF and MA caches. The caches keep driving Imiss/Dmiss to the hazard/stall unit until their done pulse.

Parameters:
- LINE_WORDS, 4: words per cache line; power of 2, at least 2.
- ADDR_W, 32: byte-address width.
- DATA_W, 32: word width; the byte address advances by 4 per word.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous active-low reset.
- i_imiss_req  in  1  I-cache refill request; held until o_imiss_done.
- i_imiss_addr  in  ADDR_W  miss address; low log2(LINE_WORDS)+2 bits ignored.
- o_imiss_rdata  out  DATA_W  refill word, driven from i_mem_rdata.
- o_imiss_rvalid  out  1  o_imiss_rdata valid this cycle.
- o_imiss_done  out  1  one-cycle pulse, burst complete.
- i_dmiss_req  in  1  D-cache request; held until o_dmiss_done.
- i_dmiss_we  in  1  1 = write-back burst, 0 = refill burst; sampled at grant.
- i_dmiss_addr  in  ADDR_W  line address; low bits ignored as for I.
- i_dmiss_wdata  in  DATA_W  write-back word for the current index.
- o_dmiss_wnext  out  1  current write word accepted; cache advances its index.
- o_dmiss_rdata  out  DATA_W  refill word.
- o_dmiss_rvalid  out  1  o_dmiss_rdata valid.
- o_dmiss_done  out  1  one-cycle pulse, burst complete.
- o_word_idx  out  log2(LINE_WORDS)  current beat index within the burst.
- o_mem_req  out  1  memory transfer request.
- o_mem_we  out  1  memory write.
- o_mem_addr  out  ADDR_W  word address of the current beat.
- o_mem_wdata  out  DATA_W  write data (i_dmiss_wdata passthrough).
- i_mem_ready  in  1  beat handshake: write accepted or read data valid.
- i_mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset (Rst=0, asynchronous):
  - state=IDLE, counter=0, last_grant=I.
  - base address register and we register cleared.
  - All outputs 0.
  - Reset mid-burst abandons the burst and emits no done pulse.
- States: IDLE, I_BURST, D_BURST, I_DONE, D_DONE.
- IDLE:
  - Only D requesting -> D_BURST.
  - Only I requesting -> I_BURST.
  - Both requesting -> grant the path not equal to last_grant; after reset D wins first.
  - On grant, latch the base address (low bits zeroed) and i_dmiss_we, clear the counter, and update last_grant.
  - Grant latency: request seen in cycle N, o_mem_req=1 in cycle N+1.
- Burst states:
  - o_mem_req=1.
  - o_mem_addr = base + counter*4.
  - o_mem_we = latched we in D_BURST, 0 in I_BURST.
  - Each cycle with i_mem_ready=1 is one beat and increments the counter.
  - Read beat: rvalid=1 to the granted path only, combinationally with i_mem_ready; rdata passes through.
  - Write beat: o_dmiss_wnext=1.
  - i_mem_ready=0 holds all outputs and the counter stable; there is no timeout.
  - Beat with counter = LINE_WORDS-1 -> X_DONE; the counter wraps to 0.
- X_DONE:
  - The matching done output is high for exactly one cycle, o_mem_req=0, then IDLE.
  - Requests are ignored in X_DONE. The requester drops req in the cycle after done.
  - The earliest next grant is therefore 2 cycles after the last beat.
- Request dropped mid-burst: ignored; the burst completes and done still pulses.
- o_word_idx equals the counter in every state.
- rvalid, wnext and done outputs are 0 whenever their path is not granted.

Decomposition:
- Shared defines file alongside the existing pipeline defines holds:
  - state encodings (MARB_IDLE, MARB_I_BURST, MARB_D_BURST, MARB_I_DONE, MARB_D_DONE);
  - grant constants MARB_GNT_I=0, MARB_GNT_D=1.
- One sub-module: mem_burst_counter. It is a word counter with clear, increment and last-beat flag, parameterised by LINE_WORDS.

Test Plan:
- Reset, then I req with addr 0x0000_104C and i_mem_ready always 1:
  - o_mem_addr = 0x1040, 0x1044, 0x1048, 0x104C on 4 consecutive cycles;
  - 4 o_imiss_rvalid pulses, o_mem_we=0;
  - o_imiss_done pulses the following cycle.
- D write-back, addr 0x2000, i_mem_ready pattern 1,0,0,1,1,1:
  - o_dmiss_wnext pulses exactly 4 times;
  - o_mem_addr holds 0x2004 during the wait cycles;
  - o_mem_we=1 throughout; done pulses after the 4th beat.
- I and D request in the same cycle after reset:
  - D granted first, I second;
  - repeating the simultaneous request grants in the order I, D (alternating).
- I requester drops req after beat 2:
  - the burst still completes 4 beats and o_imiss_done pulses;
  - the arbiter returns to IDLE.
- Rst asserted while counter=2 in D_BURST:
  - all outputs 0 immediately, no done pulse;
  - after release a new I request starts at beat 0.
- D refill with i_mem_rdata = 0xA0..0xA3:
  - o_dmiss_rdata matches in each rvalid cycle;
  - o_imiss_rvalid stays 0 throughout.
